// File: rtl/flop_chain_sequencer.sv
// rtl/flop_chain_sequencer.sv - shifts words through a serial flop chain and captures them back
`timescale 1ps/1ps

module flop_chain_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             chain_d,
    input  logic             chain_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             mismatch,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + DEPTH + 1);
    localparam logic [CW-1:0] CNT_WLIM = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH + DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] ref_word;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] cap_word;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Drive the chain with the current LSB while bits remain, zeros otherwise.
    always_comb begin
        chain_d = 1'b0;
        if (state == RUN && cnt < CNT_WLIM) begin
            chain_d = sreg[0];
        end
    end

    // Captured word including the bit arriving on this edge, so the final
    // compare sees the complete word.
    always_comb begin
        cap_word = out_data;
        if (state == RUN) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt == CW'(DEPTH + i)) begin
                    cap_word[i] = chain_q;
                end
            end
        end
    end

    // Sequencer FSM: accept, shift/flush/capture, then hold the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sreg      <= '0;
            ref_word  <= '0;
            cnt       <= '0;
            out_data  <= '0;
            mismatch  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg     <= in_data;
                        ref_word <= in_data;
                        cnt      <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt < CNT_WLIM) begin
                        sreg <= sreg >> 1;
                    end
                    out_data <= cap_word;
                    cnt      <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        mismatch  <= (cap_word != ref_word);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flop_chain_sequencer.sv
// tb/tb_flop_chain_sequencer.sv - directed bench for flop_chain_sequencer with a modelled flop chain
`timescale 1ps/1ps

module tb_flop_chain_sequencer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         chain_d;
    logic         chain_q;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         mismatch;
    logic         busy;

    logic [D-1:0] chain = '0;
    logic         force_q = 1'b0;
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;

    flop_chain_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .chain_d   (chain_d),
        .chain_q   (chain_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mismatch  (mismatch),
        .busy      (busy)
    );

    always #50 clk = ~clk;

    // Flop chain model and cycle counter.
    always @(posedge clk) begin
        chain <= {chain[D-2:0], chain_d};
        cyc   <= cyc + 1;
    end

    assign chain_q = force_q ? 1'b1 : chain[D-1];

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready c=%0d got=%b want=1", c, in_ready); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got=%b want=0", c, busy); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid c=%0d got=%b want=0", c, out_valid); end
            total++; if (chain_d !== 1'b0) begin bad++; $display("FAIL reset_chain_d c=%0d got=%b want=0", c, chain_d); end
            total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data c=%0d got=%h want=00", c, out_data); end
            total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL reset_mismatch c=%0d got=%b want=0", c, mismatch); end
        end
    endtask

    task automatic test_basic;
        logic [7:0] w;
        logic       exp;
        w = 8'hA5;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hFF;
        for (int k = 0; k < 12; k++) begin
            exp = (k < 8) ? w[k] : 1'b0;
            total++; if (chain_d !== exp) begin bad++; $display("FAIL basic_chain_d k=%0d got=%b want=%b", k, chain_d, exp); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid k=%0d got=%b want=0", k, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_run_in_ready k=%0d got=%b want=0", k, in_ready); end
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL basic_out_data got=%h want=a5", out_data); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL basic_mismatch got=%b want=0", mismatch); end
    endtask

    task automatic test_hold;
        int n;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        for (int c = 0; c < 20; c++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_out_valid c=%0d got=%b want=1", c, out_valid); end
            total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL hold_out_data c=%0d got=%h want=a5", c, out_data); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_busy c=%0d got=%b want=1", c, busy); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%b want=0", c, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_release_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hold_accept_busy got=%b want=1", busy); end
        wait_done(30, n);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_timeout got=%b want=1", out_valid); end
        total++; if (n !== 12) begin bad++; $display("FAIL hold_latency got=%0d want=12", n); end
        total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL hold_out_data2 got=%h want=3c", out_data); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL hold_mismatch got=%b want=0", mismatch); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_force;
        int n;
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        force_q = 1'b1;
        @(negedge clk);
        force_q = 1'b0;
        wait_done(30, n);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL force_timeout got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h04) begin bad++; $display("FAIL force_out_data got=%h want=04", out_data); end
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL force_mismatch got=%b want=1", mismatch); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL force_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid;
        int n;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rmid_out_data got=%h want=00", out_data); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL rmid_mismatch got=%b want=0", mismatch); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        total++; if (chain_d !== 1'b0) begin bad++; $display("FAIL rmid_chain_d got=%b want=0", chain_d); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_stray_valid c=%0d got=%b want=0", c, out_valid); end
        end
        in_valid = 1'b1;
        in_data  = 8'h81;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(30, n);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_timeout got=%b want=1", out_valid); end
        total++; if (out_data !== 8'h81) begin bad++; $display("FAIL rmid_out_data2 got=%h want=81", out_data); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL rmid_mismatch2 got=%b want=0", mismatch); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [3];
        logic [7:0] got [3];
        logic       gm [3];
        int         gc [3];
        int         nacc;
        int         nout;
        words = '{8'h01, 8'h80, 8'hFF};
        nacc = 0;
        nout = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && nout < 3; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got[nout] = out_data;
                gm[nout]  = mismatch;
                gc[nout]  = cyc;
                nout++;
            end
            if (nacc < 3) begin
                in_valid = 1'b1;
                in_data  = words[nacc];
                if (in_ready === 1'b1) nacc++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        total++; if (nout !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", nout); end
        for (int i = 0; i < nout; i++) begin
            total++; if (got[i] !== words[i]) begin bad++; $display("FAIL b2b_data i=%0d got=%h want=%h", i, got[i], words[i]); end
            total++; if (gm[i] !== 1'b0) begin bad++; $display("FAIL b2b_mismatch i=%0d got=%b want=0", i, gm[i]); end
        end
        for (int i = 1; i < nout; i++) begin
            total++; if (gc[i] - gc[i-1] !== 14) begin bad++; $display("FAIL b2b_spacing i=%0d got=%0d want=14", i, gc[i] - gc[i-1]); end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_hold;
        test_force;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
